// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: round-robin arbiter that time-slices one I2C master among
// NUM_REQ clients, pacing start/header/data/stop phases with a cycle counter.
module i2c_cmd_sequencer #(
   parameter int NUM_REQ     = 4,
   parameter int HDR_CYCLES  = 10,
   parameter int BYTE_CYCLES = 9,
   parameter int STOP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]   req_rw,
   input  logic [4*NUM_REQ-1:0] req_len,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   data_ack,
   output logic [NUM_REQ-1:0]   done,
   output logic                 busy,
   output logic                 m_start,
   output logic                 m_stop,
   output logic                 m_rw,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_wdata
);
   // Client handshake: req is a level held until its done pulse; gnt stays high
   // for the whole transaction; each data_ack asks for the next write byte,
   // which must be on req_data within BYTE_CYCLES-1 cycles.
   localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (HDR_CYCLES > BYTE_CYCLES) ?
                         ((HDR_CYCLES > STOP_CYCLES) ? HDR_CYCLES : STOP_CYCLES) :
                         ((BYTE_CYCLES > STOP_CYCLES) ? BYTE_CYCLES : STOP_CYCLES);
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {IDLE, START, HDR, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      byte_left;
   logic [IW-1:0]   last;
   logic [IW-1:0]   cur;
   logic [IW-1:0]   sel_idx;
   logic [IW-1:0]   scan_idx;
   logic            sel_valid;
   logic [3:0]      sel_len;

   // Scan downward so the lowest offset from last+1 is the one that sticks.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = IW'((int'(last) + k) % NUM_REQ);
         if (req[scan_idx]) begin
            sel_valid = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   assign sel_len = req_len[int'(sel_idx)*4 +: 4];

   // Outputs are precomputed one edge early so each is visible in the cycle
   // it describes (ack on a slot's first cycle, done on the last STOP cycle).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         byte_left <= '0;
         last      <= IW'(NUM_REQ - 1);
         cur       <= '0;
         gnt       <= '0;
         data_ack  <= '0;
         done      <= '0;
         busy      <= 1'b0;
         m_start   <= 1'b0;
         m_stop    <= 1'b0;
         m_rw      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
      end else begin
         m_start  <= 1'b0;
         data_ack <= '0;
         done     <= '0;
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  gnt       <= NUM_REQ'(1) << sel_idx;
                  busy      <= 1'b1;
                  m_addr    <= req_addr[int'(sel_idx)*7 +: 7];
                  m_rw      <= req_rw[sel_idx];
                  m_wdata   <= req_data[int'(sel_idx)*8 +: 8];
                  byte_left <= (sel_len == 4'd0) ? 4'd0 : sel_len - 4'd1;
                  last      <= sel_idx;
                  cur       <= sel_idx;
                  state     <= START;
               end
            end
            START: begin
               m_start <= 1'b1;
               cnt     <= CW'(HDR_CYCLES - 1);
               state   <= HDR;
            end
            HDR: begin
               if (cnt == '0) begin
                  cnt      <= CW'(BYTE_CYCLES - 1);
                  data_ack <= gnt;
                  m_stop   <= (byte_left == 4'd0);
                  state    <= DATA;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  if (byte_left != 4'd0) begin
                     if (!m_rw) m_wdata <= req_data[int'(cur)*8 +: 8];
                     byte_left <= byte_left - 4'd1;
                     cnt       <= CW'(BYTE_CYCLES - 1);
                     data_ack  <= gnt;
                     m_stop    <= (byte_left == 4'd1);
                  end else begin
                     cnt   <= CW'(STOP_CYCLES - 1);
                     state <= STOP;
                     if (STOP_CYCLES == 1) done <= gnt;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  gnt    <= '0;
                  busy   <= 1'b0;
                  m_stop <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) done <= gnt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: randomized requesters, a round-robin reference
// model feeding an expected-transaction queue, and a monitor that checks them.
module tb_i2c_cmd_sequencer;
   localparam int N   = 4;
   localparam int HDR = 10;
   localparam int BYT = 9;
   localparam int STP = 2;
   localparam int RW  = 48;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, req_rw;
   logic [7*N-1:0] req_addr;
   logic [4*N-1:0] req_len;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   gnt, data_ack, done;
   logic           busy, m_start, m_stop, m_rw;
   logic [6:0]     m_addr;
   logic [7:0]     m_wdata;

   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];
   logic tight = 1'b0;

   // Reference-model and requester-side state
   int         m_last;
   logic [7:0] tx_bytes [N][4];
   logic [6:0] s_addr [N];
   logic       s_rw [N];
   int         s_len [N];
   int         bidx [N];
   int         reps [N];

   i2c_cmd_sequencer #(.NUM_REQ(N), .HDR_CYCLES(HDR), .BYTE_CYCLES(BYT), .STOP_CYCLES(STP)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_len(req_len), .req_data(req_data), .gnt(gnt), .data_ack(data_ack), .done(done),
      .busy(busy), .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_addr(m_addr),
      .m_wdata(m_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] mk_rec(input int i);
      int eff;
      logic [31:0] b;
      eff = (s_len[i] == 0) ? 1 : s_len[i];
      b = '0;
      for (int k = 0; k < eff; k++) b[k*8 +: 8] = s_rw[i] ? tx_bytes[i][0] : tx_bytes[i][k];
      return {3'(i), s_rw[i], s_addr[i], 5'(eff), b};
   endfunction

   // Round-robin reference: requesters in mask, each wanting reps[i] grants.
   task automatic predict(input logic [N-1:0] mask);
      int rem [N];
      int total;
      int c;
      total = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = mask[i] ? reps[i] : 0;
         total += rem[i];
      end
      while (total > 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (rem[c] > 0) begin
               exp_q.push_back(mk_rec(c));
               rem[c]--;
               total--;
               m_last = c;
               break;
            end
         end
      end
   endtask

   task automatic setup(input int i, input logic [6:0] a, input logic rw, input int len, input int nrep);
      s_addr[i] = a;
      s_rw[i]   = rw;
      s_len[i]  = len;
      req_addr[i*7 +: 7] = a;
      req_rw[i]          = rw;
      req_len[i*4 +: 4]  = 4'(len);
      for (int k = 0; k < 4; k++) tx_bytes[i][k] = 8'($urandom_range(1, 255));
      req_data[i*8 +: 8] = tx_bytes[i][0];
      bidx[i] = 0;
      reps[i] = nrep;
   endtask

   task automatic set_bytes(input int i, input logic [7:0] b0, b1, b2, b3);
      tx_bytes[i][0] = b0;
      tx_bytes[i][1] = b1;
      tx_bytes[i][2] = b2;
      tx_bytes[i][3] = b3;
      req_data[i*8 +: 8] = b0;
   endtask

   // One cycle of requester behaviour: next byte on data_ack, release on done.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (done[i]) begin
            if (reps[i] > 0) reps[i]--;
            if (reps[i] == 0) req[i] = 1'b0;
            bidx[i] = 0;
            req_data[i*8 +: 8] = tx_bytes[i][0];
         end
         if (data_ack[i]) begin
            bidx[i]++;
            req_data[i*8 +: 8] = tx_bytes[i][(bidx[i] < 4) ? bidx[i] : 3];
         end
      end
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((exp_q.size() != 0 || gnt != 0) && n < budget);
      checks++;
      if (exp_q.size() != 0 || gnt != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d outstanding expected 0", name, exp_q.size());
      end
   endtask

   // Monitor: builds each observed transaction and compares against exp_q.
   int t, total, first_stop, stop_cnt, ack_cnt, start_cnt, done_t, idle_cnt, idx;
   logic in_txn = 1'b0;
   logic gap_armed = 1'b0;
   logic [N-1:0] cur_gnt;
   logic [6:0] ob_addr;
   logic ob_rw;
   logic [31:0] ob_bytes;
   logic [RW-1:0] e;

   always @(negedge clk) begin
      if (reset) begin
         in_txn = 1'b0;
         gap_armed = 1'b0;
         idle_cnt = 0;
      end else begin
         chk("busy_vs_gnt", 64'(busy), 64'(gnt != 0));
         chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
         if (gnt != 0) begin
            if (!in_txn) begin
               if (tight && gap_armed) chk("idle_gap", 64'(idle_cnt), 64'd1);
               if (!tight) gap_armed = 1'b0;
               in_txn = 1'b1;
               t = 0;
               cur_gnt = gnt;
               first_stop = -1;
               stop_cnt = 0;
               ack_cnt = 0;
               start_cnt = 0;
               done_t = -1;
               ob_bytes = '0;
               ob_addr = '0;
               ob_rw = 1'b0;
            end else begin
               t++;
            end
            chk("gnt_stable", 64'(gnt), 64'(cur_gnt));
            if (m_start) begin
               start_cnt++;
               chk("m_start_cycle", 64'(t), 64'd1);
               ob_addr = m_addr;
               ob_rw = m_rw;
            end
            if (data_ack != 0) begin
               chk("ack_index", 64'(data_ack), 64'(cur_gnt));
               chk("ack_cycle", 64'(t), 64'(1 + HDR + ack_cnt * BYT));
               if (ack_cnt < 4) ob_bytes[ack_cnt*8 +: 8] = m_wdata;
               ack_cnt++;
            end
            if (m_stop) begin
               if (first_stop < 0) first_stop = t;
               stop_cnt++;
            end
            if (done != 0) begin
               chk("done_index", 64'(done), 64'(cur_gnt));
               done_t = t;
            end
         end else begin
            if (in_txn) begin
               total = t + 1;
               idx = 0;
               for (int i = 0; i < N; i++) if (cur_gnt[i]) idx = i;
               chk("start_count", 64'(start_cnt), 64'd1);
               chk("txn_length", 64'(total), 64'(1 + HDR + ack_cnt * BYT + STP));
               chk("stop_span", 64'(stop_cnt), 64'(BYT + STP));
               chk("stop_tail", 64'(first_stop), 64'(total - (BYT + STP)));
               chk("done_last_cycle", 64'(done_t), 64'(total - 1));
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_txn: got grant %0h expected none", cur_gnt);
               end else begin
                  e = exp_q.pop_front();
                  chk("txn_record", 64'({3'(idx), ob_rw, ob_addr, 5'(ack_cnt), ob_bytes}), 64'(e));
               end
               in_txn = 1'b0;
               idle_cnt = 0;
               if (tight) gap_armed = 1'b1;
            end
            chk("idle_quiet", 64'({m_start, m_stop, data_ack, done}), 64'd0);
            idle_cnt++;
         end
      end
   end

   initial begin
      int n;
      int dcnt;
      logic [N-1:0] mask;
      reset = 1'b1;
      req = '0;
      req_rw = '0;
      req_addr = '0;
      req_len = '0;
      req_data = '0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) begin
         reps[i] = 0;
         bidx[i] = 0;
      end
      tick();
      tick();
      chk("reset_gnt", 64'(gnt), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_master", 64'({m_start, m_stop, m_rw, m_addr, m_wdata}), 64'd0);
      chk("reset_pulses", 64'({data_ack, done}), 64'd0);
      reset = 1'b0;
      tick();

      // Single write: requester 1, addr 0x50, len 1, data 0xA5
      setup(1, 7'h50, 1'b0, 1, 1);
      set_bytes(1, 8'hA5, 8'h00, 8'h00, 8'h00);
      predict(4'b0010);
      req[1] = 1'b1;
      wait_drain(200, "single_write");

      // Multi-byte write: requester 0, len 3, 0x11/0x22/0x33
      setup(0, 7'($urandom), 1'b0, 3, 1);
      set_bytes(0, 8'h11, 8'h22, 8'h33, 8'h44);
      predict(4'b0001);
      req[0] = 1'b1;
      wait_drain(200, "multi_write");

      // Read with len 0 behaves as len 1
      setup(3, 7'($urandom), 1'b1, 0, 1);
      predict(4'b1000);
      req[3] = 1'b1;
      wait_drain(200, "read_len0");

      // All four held: expect 0,1,2,3,0 back to back
      for (int i = 0; i < N; i++) setup(i, 7'($urandom), 1'($urandom), $urandom_range(1, 2), (i == 0) ? 2 : 1);
      predict(4'b1111);
      tight = 1'b1;
      req = 4'b1111;
      wait_drain(600, "all_held");
      tight = 1'b0;

      // Requester 1 drops req during HDR; requester 2 is next
      setup(1, 7'($urandom), 1'b0, 2, 1);
      predict(4'b0010);
      req[1] = 1'b1;
      n = 0;
      while (!gnt[1] && n < 20) begin
         tick();
         n++;
      end
      chk("drop_granted", 64'(gnt), 64'b0010);
      repeat (3) tick();
      req[1] = 1'b0;
      setup(2, 7'($urandom), 1'($urandom), $urandom_range(0, 4), 1);
      predict(4'b0100);
      req[2] = 1'b1;
      wait_drain(300, "drop_hdr");

      // Randomized rounds of simultaneous requests
      repeat (8) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++)
            if (mask[i]) setup(i, 7'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(1, 2));
         predict(mask);
         req = req | mask;
         wait_drain(1200, "random_round");
      end

      // Asynchronous reset in the middle of DATA
      setup(0, 7'h7F, 1'b0, 3, 1);
      set_bytes(0, 8'hC3, 8'h3C, 8'h5A, 8'h00);
      predict(4'b0001);
      req[0] = 1'b1;
      n = 0;
      while (!data_ack[0] && n < 40) begin
         tick();
         n++;
      end
      chk("reached_data", 64'(data_ack[0]), 64'd1);
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      chk("arst_gnt", 64'(gnt), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_master", 64'({m_start, m_stop, m_rw, m_addr, m_wdata}), 64'd0);
      chk("arst_pulses", 64'({data_ack, done}), 64'd0);
      req[0] = 1'b0;
      exp_q.delete();
      m_last = N - 1;
      setup(2, 7'($urandom), 1'b0, 1, 1);
      req[2] = 1'b1;
      dcnt = 0;
      repeat (3) begin
         tick();
         if (done != 0) dcnt++;
      end
      chk("no_done_on_reset", 64'(dcnt), 64'd0);
      predict(4'b0100);
      reset = 1'b0;
      wait_drain(200, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Round-robin command sequencer that shares one I2C master controller among up to NUM_REQ requesters. It arbitrates pending requests, latches the winner's address, direction, byte count and write data, and drives the master's start, stop, rw, addr and w_data inputs. It paces each transaction phase with internal cycle counters, because the master exposes no status. It sits between the on-chip client logic and the I2C master instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HDR_CYCLES, 10, cycles from the end of the start pulse to the first data-byte slot (address, rw and ack phases)
- BYTE_CYCLES, 9, cycles per data-byte slot including the ack (must be >= 2)
- STOP_CYCLES, 2, cycles spent in the stop phase

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request level per requester; held until the matching done
- req_addr  in  7*NUM_REQ  7-bit target address per requester, slice i = bits [7i+6:7i]
- req_rw  in  NUM_REQ  direction per requester (0 = write, 1 = read)
- req_len  in  4*NUM_REQ  byte count per requester; 0 is treated as 1
- req_data  in  8*NUM_REQ  current write byte per requester
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction
- data_ack  out  NUM_REQ  1-cycle pulse: current byte taken, present the next byte
- done  out  NUM_REQ  1-cycle pulse at the end of the transaction
- busy  out  1  high whenever the block is not in IDLE
- m_start  out  1  start strobe to the master
- m_stop  out  1  stop request to the master
- m_rw  out  1  direction to the master
- m_addr  out  7  address to the master
- m_wdata  out  8  write byte to the master

## Operation
- States: IDLE, START, HDR, DATA, STOP.
- All outputs are registered. Reset values: gnt, data_ack, done, busy, m_start, m_stop, m_rw = 0; m_addr = 0; m_wdata = 0. The state returns to IDLE and the round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- IDLE, with any req bit set:
  - Select the first set bit scanning from index last+1 with wrap-around, giving g.
  - Latch m_addr, m_rw and m_wdata from requester g's slices.
  - Set byte_left = max(req_len[g],1) - 1 and last = g.
  - Assert gnt[g] and busy, then go to START.
- START: m_start = 1 for exactly this one cycle, then go to HDR with cnt = HDR_CYCLES-1.
- HDR: decrement cnt. At cnt == 0, go to DATA with cnt = BYTE_CYCLES-1.
- DATA:
  - data_ack[g] pulses on the first cycle of each byte slot, so there are len pulses in total, for reads and writes alike.
  - m_stop = 1 throughout the final byte slot (byte_left == 0).
  - At cnt == 0 with byte_left > 0: m_wdata <= req_data[g], byte_left decrements, and cnt reloads.
  - At cnt == 0 with byte_left == 0: go to STOP with cnt = STOP_CYCLES-1.
- STOP: m_stop stays 1 and cnt decrements.
  - At cnt == 0: done[g] pulses and the state returns to IDLE.
  - In that same transition, gnt, busy and m_stop clear.
- Requester g deasserting req mid-transaction is ignored; the transaction completes.
- req, req_addr, req_rw, req_len and req_data are sampled only at grant and at byte-slot boundaries.
- For reads, m_wdata keeps its latched value and is a don't-care to the master.
- Simultaneous requests: exactly one grant is issued and the others wait. With all requesters continuously requesting, grants rotate 0,1,2,3,0,...
- Reset mid-operation: outputs take their reset values immediately (asynchronously). The in-flight transaction is dropped and no done is issued.

## Timing
- Arbitration latency: req sampled high in IDLE at edge T gives gnt high after T; m_start is high in the cycle after T+1.
- Transaction length from the gnt rise to the gnt fall: 1 + HDR_CYCLES + len*BYTE_CYCLES + STOP_CYCLES cycles. With defaults and len = 1 this is 22 cycles.
- Minimum gap between transactions: 1 IDLE cycle with gnt low.
- After a data_ack pulse, a requester has BYTE_CYCLES-1 cycles to present its next byte on req_data.
- gnt is always one-hot or zero. done and data_ack are only ever asserted on the granted index.

## Test plan
- Single write, requester 1, addr 0x50, len 1, data 0xA5, default params:
  - gnt = 0010 for 22 cycles.
  - One m_start pulse, with m_addr = 0x50, m_rw = 0, m_wdata = 0xA5.
  - One data_ack[1] pulse.
  - m_stop is high for the last 11 cycles.
  - done[1] pulses on the last cycle.
- Multi-byte write, requester 0, len 3, bytes 0x11/0x22/0x33 advanced on each data_ack:
  - m_wdata steps 0x11 -> 0x22 -> 0x33 at 9-cycle boundaries.
  - Three data_ack pulses.
  - Total length 40 cycles.
- All four requesters asserted simultaneously and held:
  - Grants issue in order 0,1,2,3,0, with exactly one IDLE cycle between transactions.
  - Never two gnt bits high at once.
- Read, req_rw = 1, len = 0:
  - Behaves as len 1 with m_rw = 1.
  - One data_ack pulse, then done.
- Asynchronous reset asserted in the middle of the DATA state:
  - All outputs go to 0 immediately and no done pulse is issued.
  - After release, a pending req on requester 2 is granted first (pointer reset to NUM_REQ-1, scan starts at 0, and 0 and 1 are idle).
- Requester drops req during HDR:
  - The transaction still completes and done pulses.
  - The next grant goes to the next pending requester.
